nibble_serial_subtractor: RTL and testbench

Multi-cycle 16-bit subtractor, the inverse counterpart of the datapath's 16-bit carry-lookahead adder. Computes Diff = A - B - bIn one 4-bit nibble per clock through a single shared 4-bit borrow-lookahead slice, ripple-borrowing between nibbles in a register. A start/done handshake lets the datapath controller issue subtractions and compare operations. Status flags (borrow, zero, negative, overflow) feed the ALU flag logic.

---
 rtl/nibble_serial_subtractor.sv | 185 ++++++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor
//   Multi-cycle subtractor: Diff = A - B - bIn, computed one 4-bit nibble per
//   clock through a single shared borrow-lookahead slice. The borrow ripples
//   between nibbles through a register.
//
// Ports
//   Clk      in   clock, all state updates on the rising edge
//   Rs       in   synchronous active-high reset (dominates Start)
//   Start    in   request, sampled only while Ready=1
//   A, B     in   minuend / subtrahend, captured on an accepted Start
//   bIn      in   borrow-in, captured on an accepted Start
//   Ready    out  a Start on this cycle will be accepted (IDLE or DONE)
//   Busy     out  nibbles are being processed (RUN)
//   Done     out  one-cycle pulse, results were just updated
//   Diff     out  result, held until the next completion
//   bOut     out  unsigned borrow-out (A < B + bIn)
//   Zero     out  Diff == 0
//   Neg      out  Diff[MSB]
//   Ovf      out  signed overflow of the subtraction
//   DbgState out  current FSM state encoding (0=IDLE, 1=RUN, 2=DONE)
// -----------------------------------------------------------------------------
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rs,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bIn,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             bOut,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf,
    output logic [1:0]       DbgState
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    // Shared nibble slice signals
    logic [3:0] nib_a, nib_b, nib_g, nib_p, nib_d;
    logic [4:0] nib_c;

    // -------------------------------------------------------------------------
    // Handshake: Start is a request that is accepted on any rising edge where
    // Ready=1 (IDLE or DONE); there is no back-pressure beyond Ready, a Start
    // seen while Busy is dropped rather than queued, and Done is a one-cycle
    // valid pulse with no acknowledge -- Diff/flags stay stable afterwards
    // until the next completion.
    // -------------------------------------------------------------------------

    // Borrow-lookahead slice: generate = a<b locally, propagate = a==b
    // (an incoming borrow passes through). All borrows are computed in
    // parallel from the slice's borrow-in.
    always_comb begin
        nib_a = a_q[{idx_q, 2'b00} +: 4];
        nib_b = b_q[{idx_q, 2'b00} +: 4];
        nib_g = ~nib_a & nib_b;
        nib_p = ~(nib_a ^ nib_b);
        nib_c[0] = borrow_q;
        nib_c[1] = nib_g[0] | (nib_p[0] & nib_c[0]);
        nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0])
                 | (nib_p[1] & nib_p[0] & nib_c[0]);
        nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1])
                 | (nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
        nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2])
                 | (nib_p[3] & nib_p[2] & nib_g[1])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
        nib_d = nib_a ^ nib_b ^ nib_c[3:0];
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        part_d   = part_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = bIn;
                    idx_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                part_d[{idx_q, 2'b00} +: 4] = nib_d;
                borrow_d = nib_c[4];
                idx_d    = idx_q + 1'b1;
                if (idx_q == IW'(N - 1)) begin
                    // Last nibble: publish the whole result in the same edge,
                    // including the nibble being written right now.
                    state_d = S_DONE;
                    idx_d   = '0;
                    diff_d  = part_d;
                    bout_d  = nib_c[4];
                    zero_d  = (part_d == '0);
                    neg_d   = part_d[WIDTH-1];
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                            & (part_d[WIDTH-1] ^ a_q[WIDTH-1]);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rs) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            part_q   <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            part_q   <= part_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Ready    = (state_q != S_RUN);
    assign Busy     = (state_q == S_RUN);
    assign Done     = (state_q == S_DONE);
    assign Diff     = diff_q;
    assign bOut     = bout_q;
    assign Zero     = zero_q;
    assign Neg      = neg_q;
    assign Ovf      = ovf_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_subtractor
//   Self-checking bench for nibble_serial_subtractor: directed cases,
//   back-to-back issue with Start held high, reset abort, and randomized
//   operations checked against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_nibble_serial_subtractor;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rs;
    logic         start;
    logic [W-1:0] a, b;
    logic         b_in;
    logic         ready, busy, done;
    logic [W-1:0] diff;
    logic         b_out, zero, neg, ovf;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .Clk     (clk),
        .Rs      (rs),
        .Start   (start),
        .A       (a),
        .B       (b),
        .bIn     (b_in),
        .Ready   (ready),
        .Busy    (busy),
        .Done    (done),
        .Diff    (diff),
        .bOut    (b_out),
        .Zero    (zero),
        .Neg     (neg),
        .Ovf     (ovf),
        .DbgState(dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Packed result: {bOut, Zero, Neg, Ovf, Diff}
    logic [W+3:0] exp_q[$];
    logic [W+3:0] last_res;
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbin);
        int           ua, ub, sa, sb, ud, sd, bi;
        logic [W-1:0] r;
        logic         m_bout, m_zero, m_neg, m_ovf;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        bi = mbin ? 1 : 0;
        ud = ua - ub - bi;
        sd = sa - sb - bi;
        r      = W'(ud + 65536);
        m_bout = (ua < ub + bi);
        m_zero = (r == 0);
        m_neg  = (r >= 16'h8000);
        m_ovf  = (sd < -32768) || (sd > 32767);
        return {m_bout, m_zero, m_neg, m_ovf, r};
    endfunction

    function automatic logic [W+3:0] observed();
        return {b_out, zero, neg, ovf, diff};
    endfunction

    // ---------------- driver tasks ----------------
    // Present an operation on the current (negedge) cycle with Start=1.
    task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic dbin);
        start = 1'b1;
        a     = da;
        b     = db;
        b_in  = dbin;
        exp_q.push_back(model(da, db, dbin));
    endtask

    // Advance through RUN until Done; junk=1 keeps Start high and scrambles
    // the operand inputs every RUN cycle. Returns sitting on the Done cycle.
    task automatic finish_op(input bit junk);
        int           cnt;
        logic [W+3:0] e;
        @(negedge clk);
        if (!junk) start = 1'b0;
        cnt = 0;
        while (done !== 1'b1 && cnt < 20) begin
            check("run_busy", busy, 1'b1);
            check("run_ready", ready, 1'b0);
            check("run_hold", observed(), last_res);
            if (junk) begin
                a    = W'($urandom);
                b    = W'($urandom);
                b_in = 1'($urandom);
            end
            cnt++;
            @(negedge clk);
        end
        check("done_seen", done, 1'b1);
        check("latency", cnt, 4);
        check("done_ready", ready, 1'b1);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check("diff", diff, e[W-1:0]);
            check("b_out", b_out, e[W+3]);
            check("zero", zero, e[W+2]);
            check("neg", neg, e[W+1]);
            check("ovf", ovf, e[W]);
            last_res = e;
        end
    endtask

    // Stay idle for n cycles, checking outputs hold and no spurious Done.
    task automatic idle_hold(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_done", done, 1'b0);
            check("idle_ready", ready, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_hold", observed(), last_res);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           gap;
        logic [W-1:0] ra, rb;
        logic [W-1:0] corner[4];

        rs = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        last_res = '0;
        corner[0] = 16'h0000; corner[1] = 16'hFFFF;
        corner[2] = 16'h8000; corner[3] = 16'h7FFF;

        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", observed(), '0);
        check("rst_state", dbg_state, 2'd0);
        rs = 1'b0;
        @(negedge clk);

        // First directed case, then a long hold
        drive(16'h1234, 16'h0235, 1'b0);
        finish_op(1'b0);
        check("tp1_diff_const", diff, 16'h0FFF);
        idle_hold(10);

        drive(16'h0000, 16'h0001, 1'b0); finish_op(1'b0); idle_hold(1);
        drive(16'h8000, 16'h0001, 1'b0); finish_op(1'b0); idle_hold(1);
        drive(16'h7FFF, 16'hFFFF, 1'b0); finish_op(1'b0);
        drive(16'h5A5A, 16'h5A5A, 1'b0); finish_op(1'b0);
        check("zero_const", zero, 1'b1);
        drive(16'h5A5A, 16'h5A5A, 1'b1); finish_op(1'b0);
        check("bin_wrap_const", diff, 16'hFFFF);
        idle_hold(2);

        // Start held high with changing operands through RUN; second op
        // is accepted in the DONE cycle and completes 5 cycles later.
        drive(16'hC0DE, 16'h1F2E, 1'b1);
        finish_op(1'b1);
        drive(16'h0042, 16'h0043, 1'b0);
        finish_op(1'b0);
        idle_hold(2);

        // Reset during the second RUN cycle aborts the operation
        drive(16'h4321, 16'h1111, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_busy_pre", busy, 1'b1);
        rs = 1'b1;
        @(negedge clk);
        rs = 1'b0;
        void'(exp_q.pop_back());
        last_res = '0;
        check("abort_ready", ready, 1'b1);
        check("abort_state", dbg_state, 2'd0);
        check("abort_result", observed(), '0);
        check("abort_done", done, 1'b0);
        idle_hold(3);
        drive(16'h4321, 16'h1111, 1'b0);
        finish_op(1'b0);
        idle_hold(1);

        // Randomized operations, mixing back-to-back and gapped issue
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            drive(ra, rb, 1'($urandom_range(0, 1)));
            finish_op(1'($urandom_range(0, 1)));
            gap = $urandom_range(0, 2);
            if (gap != 0) idle_hold(gap);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
